// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver with hex decode, per-digit blank/blink/dp,
// and a double-buffered input that only switches over at a frame boundary.
module seg7_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int GUARD          = 2,
  parameter int BLINK_FRAMES   = 64,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CW-1:0] SCAN_MAX  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
  localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_MAX = FW'(BLINK_FRAMES - 1);

  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [CW-1:0]           scan_cnt_q, scan_cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic                    blink_phase_q, blink_phase_d;
  logic                    pending_q, pending_d;
  logic                    frame_tick_q, frame_tick_d;

  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_blank_q, sh_blank_d;
  logic [NUM_DIGITS-1:0]   sh_blink_q, sh_blink_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;

  logic [4*NUM_DIGITS-1:0] act_digits_q, act_digits_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    slot_end;
  logic                    boundary;
  logic [3:0]              cur_digit;
  logic                    cur_blank, cur_blink, cur_dp, dark;
  logic [6:0]              seg_on;
  logic [NUM_DIGITS-1:0]   an_on;

  assign slot_end = (scan_cnt_q == SCAN_MAX);
  assign boundary = slot_end && (idx_q == IDX_MAX);

  always_comb begin
    scan_cnt_d    = slot_end ? '0 : scan_cnt_q + 1'b1;
    idx_d         = idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
    if (boundary) begin
      if (frame_cnt_q == FRAME_MAX) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
    // Registered so the pulse lines up with the wrap cycle itself
    frame_tick_d = (scan_cnt_d == SCAN_MAX) && (idx_d == IDX_MAX);
  end

  always_comb begin
    sh_digits_d  = sh_digits_q;
    sh_blank_d   = sh_blank_q;
    sh_blink_d   = sh_blink_q;
    sh_dp_d      = sh_dp_q;
    act_digits_d = act_digits_q;
    act_blank_d  = act_blank_q;
    act_blink_d  = act_blink_q;
    act_dp_d     = act_dp_q;
    pending_d    = pending_q;
    if (load) begin
      sh_digits_d = digits_in;
      sh_blank_d  = blank_in;
      sh_blink_d  = blink_in;
      sh_dp_d     = dp_in;
      pending_d   = 1'b1;
    end
    // A load landing on the boundary bypasses the shadow so it is never a frame late
    if (boundary) begin
      pending_d = 1'b0;
      if (load) begin
        act_digits_d = digits_in;
        act_blank_d  = blank_in;
        act_blink_d  = blink_in;
        act_dp_d     = dp_in;
      end else if (pending_q) begin
        act_digits_d = sh_digits_q;
        act_blank_d  = sh_blank_q;
        act_blink_d  = sh_blink_q;
        act_dp_d     = sh_dp_q;
      end
    end
  end

  always_comb begin
    cur_digit = 4'h0;
    cur_blank = 1'b1;
    cur_blink = 1'b0;
    cur_dp    = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur_digit = act_digits_q[4*k +: 4];
        cur_blank = act_blank_q[k];
        cur_blink = act_blink_q[k];
        cur_dp    = act_dp_q[k];
      end
    end
    dark = cur_blank | (cur_blink & blink_phase_q);

    case (cur_digit)
      4'h0:    seg_on = 7'b1111110;
      4'h1:    seg_on = 7'b0110000;
      4'h2:    seg_on = 7'b1101101;
      4'h3:    seg_on = 7'b1111001;
      4'h4:    seg_on = 7'b0110011;
      4'h5:    seg_on = 7'b1011011;
      4'h6:    seg_on = 7'b1011111;
      4'h7:    seg_on = 7'b1110000;
      4'h8:    seg_on = 7'b1111111;
      4'h9:    seg_on = 7'b1111011;
      4'hA:    seg_on = 7'b1110111;
      4'hB:    seg_on = 7'b0011111;
      4'hC:    seg_on = 7'b1001110;
      4'hD:    seg_on = 7'b0111101;
      4'hE:    seg_on = 7'b1001111;
      default: seg_on = 7'b1000111;
    endcase

    // Anodes stay off for the first GUARD cycles of every slot to hide ghosting
    an_on = '0;
    if (scan_cnt_q >= GUARD_CNT) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_on[k] = (idx_q == IW'(k));
      end
    end

    seg_d = (dark ? 7'h00 : seg_on) ^ SEG_OFF;
    dp_d  = (~dark & cur_dp) ^ DP_OFF;
    an_d  = an_on ^ AN_OFF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      pending_q     <= 1'b0;
      frame_tick_q  <= 1'b0;
      sh_digits_q   <= '0;
      sh_blank_q    <= '1;
      sh_blink_q    <= '0;
      sh_dp_q       <= '0;
      act_digits_q  <= '0;
      act_blank_q   <= '1;
      act_blink_q   <= '0;
      act_dp_q      <= '0;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
    end else begin
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      frame_tick_q  <= frame_tick_d;
      sh_digits_q   <= sh_digits_d;
      sh_blank_q    <= sh_blank_d;
      sh_blink_q    <= sh_blink_d;
      sh_dp_q       <= sh_dp_d;
      act_digits_q  <= act_digits_d;
      act_blank_q   <= act_blank_d;
      act_blink_q   <= act_blink_d;
      act_dp_q      <= act_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign seg_out    = seg_q;
  assign dp_out     = dp_q;
  assign an_out     = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: 4 digits, 4-cycle slots, 1 guard cycle, 2-frame blink.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  blank_in = 4'hF;
  logic [3:0]  blink_in = 4'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        pending;
  logic        frame_tick;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  an_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Active-low segment patterns for the directed loads
  logic [6:0] load_seg [0:3] = '{7'b0000001, 7'b0000110, 7'b0100100, 7'b0001000};
  logic [6:0] coin_seg [0:3] = '{7'b1001100, 7'b0110001, 7'b1001111, 7'b0110000};

  seg7_scan_driver #(
    .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digits_in(digits_in),
    .blank_in(blank_in), .blink_in(blink_in), .dp_in(dp_in),
    .pending(pending), .frame_tick(frame_tick), .seg_out(seg_out),
    .dp_out(dp_out), .an_out(an_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  task step;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  // Advance until cyc lands on the given position within a 16-cycle frame
  task goto_phase(input int m);
    int n;
    n = 0;
    while ((cyc % 16) != m && n < 40) begin
      step;
      n++;
    end
  endtask

  // Outputs after c edges reflect scan state c-1: slot = (c-1)/4, guard when (c-1)%4 == 0
  function automatic logic [3:0] exp_an(input int c);
    logic [3:0] one;
    int s;
    one = 4'b0001;
    if (c < 1) return 4'hF;
    s = c - 1;
    if ((s % 4) == 0) return 4'hF;
    return ~(one << ((s / 4) % 4));
  endfunction

  task test_reset;
    #12;
    checks++; if (an_out !== 4'hF) begin errors++; $display("[TB] FAIL reset_an got=%b exp=1111", an_out); end
    checks++; if (seg_out !== 7'h7F) begin errors++; $display("[TB] FAIL reset_seg got=%b exp=1111111", seg_out); end
    checks++; if (dp_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp got=%b exp=1", dp_out); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got=%b exp=0", pending); end
    checks++; if (frame_tick !== 1'b0) begin errors++; $display("[TB] FAIL reset_tick got=%b exp=0", frame_tick); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task test_idle;
    for (int k = 0; k < 40; k++) begin
      step;
      checks++; if (an_out !== exp_an(cyc)) begin errors++; $display("[TB] FAIL idle_an cyc=%0d got=%b exp=%b", cyc, an_out, exp_an(cyc)); end
      checks++; if (seg_out !== 7'h7F) begin errors++; $display("[TB] FAIL idle_seg cyc=%0d got=%b exp=1111111", cyc, seg_out); end
      checks++; if (dp_out !== 1'b1) begin errors++; $display("[TB] FAIL idle_dp cyc=%0d got=%b exp=1", cyc, dp_out); end
      checks++; if (frame_tick !== ((cyc % 16) == 15)) begin errors++; $display("[TB] FAIL idle_tick cyc=%0d got=%b exp=%b", cyc, frame_tick, ((cyc % 16) == 15)); end
      checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL idle_pending cyc=%0d got=%b exp=0", cyc, pending); end
    end
  endtask

  task test_load;
    goto_phase(2);
    digits_in = 16'hA530; blank_in = 4'h0; blink_in = 4'h0; dp_in = 4'b0010;
    load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL load_pending_set got=%b exp=1", pending); end
    goto_phase(7);
    checks++; if (seg_out !== 7'h7F) begin errors++; $display("[TB] FAIL load_no_tear got=%b exp=1111111", seg_out); end
    goto_phase(15);
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL load_pending_hold got=%b exp=1", pending); end
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL load_tick got=%b exp=1", frame_tick); end
    step;
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL load_pending_clr got=%b exp=0", pending); end
    for (int d = 0; d < 4; d++) begin
      goto_phase(4 * d + 3);
      checks++; if (seg_out !== load_seg[d]) begin errors++; $display("[TB] FAIL load_seg d=%0d got=%b exp=%b", d, seg_out, load_seg[d]); end
      checks++; if (dp_out !== (d != 1)) begin errors++; $display("[TB] FAIL load_dp d=%0d got=%b exp=%b", d, dp_out, (d != 1)); end
      checks++; if (an_out !== exp_an(cyc)) begin errors++; $display("[TB] FAIL load_an d=%0d got=%b exp=%b", d, an_out, exp_an(cyc)); end
    end
  endtask

  task test_back_to_back;
    goto_phase(2);
    digits_in = 16'h1111; dp_in = 4'h0;
    load = 1'b1;
    step;
    load = 1'b0;
    goto_phase(6);
    digits_in = 16'h2222;
    load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pending_set got=%b exp=1", pending); end
    goto_phase(11);
    checks++; if (seg_out !== 7'b0100100) begin errors++; $display("[TB] FAIL b2b_old_d2 got=%b exp=0100100", seg_out); end
    goto_phase(15);
    checks++; if (seg_out !== 7'b0001000) begin errors++; $display("[TB] FAIL b2b_old_d3 got=%b exp=0001000", seg_out); end
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL b2b_pending_hold got=%b exp=1", pending); end
    step;
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL b2b_pending_clr got=%b exp=0", pending); end
    for (int d = 0; d < 4; d++) begin
      goto_phase(4 * d + 3);
      checks++; if (seg_out !== 7'b0010010) begin errors++; $display("[TB] FAIL b2b_seg d=%0d got=%b exp=0010010", d, seg_out); end
      checks++; if (dp_out !== 1'b1) begin errors++; $display("[TB] FAIL b2b_dp d=%0d got=%b exp=1", d, dp_out); end
    end
  endtask

  task test_coincident;
    goto_phase(15);
    checks++; if (frame_tick !== 1'b1) begin errors++; $display("[TB] FAIL coin_tick got=%b exp=1", frame_tick); end
    digits_in = 16'hE1C4;
    load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL coin_pending got=%b exp=0", pending); end
    for (int d = 0; d < 4; d++) begin
      goto_phase(4 * d + 3);
      checks++; if (seg_out !== coin_seg[d]) begin errors++; $display("[TB] FAIL coin_seg d=%0d got=%b exp=%b", d, seg_out, coin_seg[d]); end
      checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL coin_pending_stay d=%0d got=%b exp=0", d, pending); end
    end
  endtask

  task test_blink;
    int dark_frames;
    logic lit;
    dark_frames = 0;
    goto_phase(2);
    digits_in = 16'h8888; blink_in = 4'b0001;
    load = 1'b1;
    step;
    load = 1'b0;
    blink_in = 4'h0;
    goto_phase(0);
    // Blink phase flips every 2 frame boundaries counted from reset release
    for (int f = 0; f < 4; f++) begin
      goto_phase(3);
      lit = (((cyc / 16) / 2) % 2) == 0;
      if (!lit) dark_frames++;
      checks++; if (seg_out !== (lit ? 7'h00 : 7'h7F)) begin errors++; $display("[TB] FAIL blink_d0 frame=%0d got=%b exp=%b", cyc / 16, seg_out, (lit ? 7'h00 : 7'h7F)); end
      checks++; if (an_out !== 4'b1110) begin errors++; $display("[TB] FAIL blink_an frame=%0d got=%b exp=1110", cyc / 16, an_out); end
      goto_phase(7);
      checks++; if (seg_out !== 7'h00) begin errors++; $display("[TB] FAIL blink_d1 frame=%0d got=%b exp=0000000", cyc / 16, seg_out); end
    end
    checks++; if (dark_frames != 2) begin errors++; $display("[TB] FAIL blink_dark_count got=%0d exp=2", dark_frames); end
  endtask

  task test_reset_mid;
    goto_phase(8);
    digits_in = 16'h1234; blank_in = 4'h0;
    load = 1'b1;
    step;
    load = 1'b0;
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL rmid_pending_set got=%b exp=1", pending); end
    step;
    checks++; if (an_out !== 4'b1011) begin errors++; $display("[TB] FAIL rmid_an_d2 got=%b exp=1011", an_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (an_out !== 4'hF) begin errors++; $display("[TB] FAIL rmid_an got=%b exp=1111", an_out); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL rmid_pending got=%b exp=0", pending); end
    checks++; if (seg_out !== 7'h7F) begin errors++; $display("[TB] FAIL rmid_seg got=%b exp=1111111", seg_out); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int k = 0; k < 20; k++) begin
      step;
      checks++; if (an_out !== exp_an(cyc)) begin errors++; $display("[TB] FAIL rmid_scan cyc=%0d got=%b exp=%b", cyc, an_out, exp_an(cyc)); end
      checks++; if (seg_out !== 7'h7F) begin errors++; $display("[TB] FAIL rmid_blank cyc=%0d got=%b exp=1111111", cyc, seg_out); end
    end
  endtask

  initial begin
    $display("[TB] seg7_scan_driver directed bench start");
    test_reset;
    test_idle;
    test_load;
    test_back_to_back;
    test_coincident;
    test_blink;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
